bbox_pixel_scanner: RTL and testbench

//  Rasterizer front stage. Takes one triangle as three 24.8 signed fixed-point vertices.

---
 rtl/bbox_pixel_scanner.sv | 198 +++++++++++++++++++
 tb/tb_bbox_pixel_scanner.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bbox_pixel_scanner.sv
// bbox_pixel_scanner
// Rasterizer front stage: takes one triangle (three signed 24.8 vertices),
// computes its screen-clipped integer bounding box and walks it row-major,
// presenting one pixel coordinate per valid/ready transfer downstream.
module bbox_pixel_scanner #(
  parameter int          SCREEN_W = 640,
  parameter int          SCREEN_H = 480,
  parameter int unsigned X_W      = 10,
  parameter int unsigned Y_W      = 9
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                tri_valid,
  output logic                tri_ready,
  input  logic signed [31:0]  v0_x,
  input  logic signed [31:0]  v0_y,
  input  logic signed [31:0]  v1_x,
  input  logic signed [31:0]  v1_y,
  input  logic signed [31:0]  v2_x,
  input  logic signed [31:0]  v2_y,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic [X_W-1:0]      pix_x,
  output logic [Y_W-1:0]      pix_y,
  output logic                pix_last,
  output logic                busy,
  output logic                done
);

  // Box end coordinates can equal the screen size, so they carry one extra bit.
  localparam int unsigned XB = X_W + 1;
  localparam int unsigned YB = Y_W + 1;
  localparam int unsigned CW = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_SCAN  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state;

  // Latched vertex coordinates of the triangle being processed.
  logic signed [CW-1:0] vx [3];
  logic signed [CW-1:0] vy [3];

  // Registered half-open box [xs_r, xe_r) x [ys_r, ye_r).
  logic [X_W-1:0] xs_r;
  logic [XB-1:0]  xe_r;
  logic [YB-1:0]  ye_r;

  // Bounding-box arithmetic, evaluated from the latched vertices.
  logic signed [CW-1:0] min_x, max_x, min_y, max_y;
  logic signed [CW-1:0] lo_x, hi_x, lo_y, hi_y;
  logic signed [CW-1:0] sx_c, ex_c, sy_c, ey_c;
  logic                 empty_c;
  logic                 first_last_c;

  // Scan-advance values for the pixel following the presented one.
  logic [XB-1:0]  x_inc_c;
  logic           row_wrap_c;
  logic [X_W-1:0] nx_c;
  logic [Y_W-1:0] ny_c;
  logic           n_last_c;

  // Ceiling of a 24.8 value, returned as an integer pixel coordinate.
  // Clearing the fraction after adding one whole unit rounds toward +inf
  // for negative values too (e.g. -1.5 -> -1).
  function automatic logic signed [CW-1:0] ceil_to_px(input logic signed [CW-1:0] v);
    logic signed [CW-1:0] r;
    r = v + 32'sd256;
    if (v[7:0] == 8'd0) begin
      r = v;
    end else begin
      r = {r[CW-1:8], 8'd0};
    end
    return r >>> 8;
  endfunction

  // Min/max of the vertices, ceiling rounding and screen clipping.
  always_comb begin
    min_x = vx[0];
    max_x = vx[0];
    min_y = vy[0];
    max_y = vy[0];
    for (int i = 1; i < 3; i++) begin
      if (vx[i] < min_x) min_x = vx[i];
      if (vx[i] > max_x) max_x = vx[i];
      if (vy[i] < min_y) min_y = vy[i];
      if (vy[i] > max_y) max_y = vy[i];
    end
    lo_x = ceil_to_px(min_x);
    hi_x = ceil_to_px(max_x);
    lo_y = ceil_to_px(min_y);
    hi_y = ceil_to_px(max_y);
    sx_c = (lo_x < 32'sd0) ? 32'sd0 : lo_x;
    ex_c = (hi_x > SCREEN_W) ? SCREEN_W : hi_x;
    sy_c = (lo_y < 32'sd0) ? 32'sd0 : lo_y;
    ey_c = (hi_y > SCREEN_H) ? SCREEN_H : hi_y;
    empty_c      = (sx_c >= ex_c) || (sy_c >= ey_c);
    first_last_c = (sx_c == ex_c - 32'sd1) && (sy_c == ey_c - 32'sd1);
  end

  // Next pixel position in row-major order, with wrap to the next row.
  always_comb begin
    x_inc_c    = {1'b0, pix_x} + XB'(1);
    row_wrap_c = (x_inc_c >= xe_r);
    nx_c       = row_wrap_c ? xs_r : x_inc_c[X_W-1:0];
    ny_c       = row_wrap_c ? (pix_y + Y_W'(1)) : pix_y;
    n_last_c   = ({1'b0, nx_c} == (xe_r - XB'(1))) &&
                 ({1'b0, ny_c} == (ye_r - YB'(1)));
  end

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      tri_ready <= 1'b1;
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      xs_r      <= '0;
      xe_r      <= '0;
      ye_r      <= '0;
      for (int i = 0; i < 3; i++) begin
        vx[i] <= '0;
        vy[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (tri_valid && tri_ready) begin
            vx[0]     <= v0_x;
            vy[0]     <= v0_y;
            vx[1]     <= v1_x;
            vy[1]     <= v1_y;
            vx[2]     <= v2_x;
            vy[2]     <= v2_y;
            tri_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (empty_c) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            xs_r      <= sx_c[X_W-1:0];
            xe_r      <= ex_c[XB-1:0];
            ye_r      <= ey_c[YB-1:0];
            pix_x     <= sx_c[X_W-1:0];
            pix_y     <= sy_c[Y_W-1:0];
            pix_last  <= first_last_c;
            pix_valid <= 1'b1;
            state     <= S_SCAN;
          end
        end

        S_SCAN: begin
          if (pix_valid && pix_ready) begin
            if (pix_last) begin
              pix_valid <= 1'b0;
              pix_last  <= 1'b0;
              done      <= 1'b1;
              state     <= S_DONE;
            end else begin
              pix_x    <= nx_c;
              pix_y    <= ny_c;
              pix_last <= n_last_c;
            end
          end
        end

        S_DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          tri_ready <= 1'b1;
          state     <= S_IDLE;
        end

        default: begin
          state     <= S_IDLE;
          tri_ready <= 1'b1;
          pix_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bbox_pixel_scanner.sv
// Self-checking bench for bbox_pixel_scanner: directed triangles plus random
// triangles under random backpressure, checked against a box/pixel-list model.
module tb_bbox_pixel_scanner;

  localparam int SW = 640;
  localparam int SH = 480;

  logic               CLK;
  logic               RESET;
  logic               tri_valid;
  logic               tri_ready;
  logic signed [31:0] v0_x, v0_y, v1_x, v1_y, v2_x, v2_y;
  logic               pix_valid;
  logic               pix_ready;
  logic [9:0]         pix_x;
  logic [8:0]         pix_y;
  logic               pix_last;
  logic               busy;
  logic               done;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int last_cyc = -100;
  int xfer_cnt = 0;
  int rdy_pct  = 100;
  bit in_reset = 0;
  bit stall_prev = 0;

  typedef struct {
    int x;
    int y;
    bit last;
  } pix_t;

  pix_t exp_q[$];

  bbox_pixel_scanner #(
    .SCREEN_W(SW),
    .SCREEN_H(SH),
    .X_W(10),
    .Y_W(9)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .tri_valid(tri_valid),
    .tri_ready(tri_ready),
    .v0_x(v0_x),
    .v0_y(v0_y),
    .v1_x(v1_x),
    .v1_y(v1_y),
    .v2_x(v2_x),
    .v2_y(v2_y),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .pix_last(pix_last),
    .busy(busy),
    .done(done)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc++;

  // Random downstream readiness, changed just after each active edge.
  always @(posedge CLK) begin
    #1;
    pix_ready = (int'($urandom_range(99)) < rdy_pct);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Integer ceiling of a 24.8 value divided by 256.
  function automatic int ceil_px(input int v);
    if (v >= 0) return (v + 255) / 256;
    else        return -((-v) / 256);
  endfunction

  function automatic int min3(input int a, input int b, input int c);
    int m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  task automatic box_of(input int ax, input int ay, input int bx, input int by,
                        input int cx, input int cy,
                        output int xs, output int xe, output int ys, output int ye);
    xs = ceil_px(min3(ax, bx, cx));
    xe = ceil_px(max3(ax, bx, cx));
    ys = ceil_px(min3(ay, by, cy));
    ye = ceil_px(max3(ay, by, cy));
    if (xs < 0) xs = 0;
    if (ys < 0) ys = 0;
    if (xe > SW) xe = SW;
    if (ye > SH) ye = SH;
  endtask

  // Pixel checker: every presented pixel must match the head of the expected list.
  always @(negedge CLK) begin
    if (!in_reset && !RESET) begin
      if (stall_prev) chk("valid held while stalled", int'(pix_valid), 1);
      if (pix_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected pixel: got (%0d,%0d), expected none", pix_x, pix_y);
        end else begin
          chk("pix_x", int'(pix_x), exp_q[0].x);
          chk("pix_y", int'(pix_y), exp_q[0].y);
          chk("pix_last", int'(pix_last), int'(exp_q[0].last));
          if (pix_ready) begin
            if (exp_q[0].last) last_cyc = cyc;
            void'(exp_q.pop_front());
            xfer_cnt++;
          end
        end
      end
      stall_prev = pix_valid && !pix_ready;
    end else begin
      stall_prev = 0;
    end
  end

  task automatic push_pixels(input int xs, input int xe, input int ys, input int ye);
    for (int y = ys; y < ye; y++)
      for (int x = xs; x < xe; x++)
        exp_q.push_back('{x: x, y: y, last: (x == xe - 1 && y == ye - 1)});
  endtask

  task automatic offer(input int ax, input int ay, input int bx, input int by,
                       input int cx, input int cy);
    @(negedge CLK);
    v0_x = ax; v0_y = ay; v1_x = bx; v1_y = by; v2_x = cx; v2_y = cy;
    tri_valid = 1'b1;
    chk("tri_ready in idle", int'(tri_ready), 1);
    @(posedge CLK);
    #1 tri_valid = 1'b0;
  endtask

  task automatic run_tri(input int ax, input int ay, input int bx, input int by,
                         input int cx, input int cy, input int rdy);
    int xs, xe, ys, ye;
    bit empty, seen;
    box_of(ax, ay, bx, by, cx, cy, xs, xe, ys, ye);
    empty = (xs >= xe) || (ys >= ye);
    if (!empty) push_pixels(xs, xe, ys, ye);
    rdy_pct = rdy;
    offer(ax, ay, bx, by, cx, cy);
    @(negedge CLK);
    chk("setup pix_valid", int'(pix_valid), 0);
    chk("setup busy", int'(busy), 1);
    chk("setup tri_ready", int'(tri_ready), 0);
    chk("setup done", int'(done), 0);
    @(negedge CLK);
    if (empty) begin
      chk("empty done latency", int'(done), 1);
      chk("empty no pixel", int'(pix_valid), 0);
    end else begin
      chk("first pixel latency", int'(pix_valid), 1);
      seen = 0;
      for (int i = 0; i < 5000; i++) begin
        if (done) begin
          seen = 1;
          break;
        end
        @(negedge CLK);
      end
      if (!seen) begin
        chk("done timeout", 0, 1);
      end else begin
        chk("all pixels sent", exp_q.size(), 0);
        chk("done one cycle after last", cyc, last_cyc + 1);
      end
      exp_q.delete();
    end
    @(negedge CLK);
    chk("done is a pulse", int'(done), 0);
    chk("tri_ready back", int'(tri_ready), 1);
    chk("busy clear", int'(busy), 0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " tri_ready"}, int'(tri_ready), 1);
    chk({tag, " pix_valid"}, int'(pix_valid), 0);
    chk({tag, " pix_x"}, int'(pix_x), 0);
    chk({tag, " pix_y"}, int'(pix_y), 0);
    chk({tag, " pix_last"}, int'(pix_last), 0);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " done"}, int'(done), 0);
  endtask

  function automatic int rand_coord(input int base);
    return (base + int'($urandom_range(12))) * 256 + int'($urandom_range(255));
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int xs, xe, ys, ye, base, bxp, byp;
    RESET = 1'b1;
    tri_valid = 1'b0;
    pix_ready = 1'b0;
    v0_x = 0; v0_y = 0; v1_x = 0; v1_y = 0; v2_x = 0; v2_y = 0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset_values("reset");
    RESET = 1'b0;

    // Pin the model with hand-computed values.
    chk("model ceil(-2.5)", ceil_px(-640), -2);
    chk("model ceil(-1.0)", ceil_px(-256), -1);
    chk("model ceil(1.25)", ceil_px(320), 2);
    box_of(384, 384, 768, 320, 576, 896, xs, xe, ys, ye);
    chk("model T1 xs", xs, 2); chk("model T1 xe", xe, 3);
    chk("model T1 ys", ys, 2); chk("model T1 ye", ye, 4);
    box_of(-640, -256, 256, 0, 128, 512, xs, xe, ys, ye);
    chk("model T2 xs", xs, 0); chk("model T2 xe", xe, 1);
    chk("model T2 ys", ys, 0); chk("model T2 ye", ye, 2);
    box_of(161280, 120320, 179200, 120320, 161280, 128000, xs, xe, ys, ye);
    chk("model T5 xe", xe, 640); chk("model T5 ye", ye, 480);

    // T1 basic
    run_tri(384, 384, 768, 320, 576, 896, 100);
    // T2 negative clip
    run_tri(-640, -256, 256, 0, 128, 512, 100);
    // T3 empty box
    run_tri(1280, 256, 1280, 512, 1280, 768, 100);
    // T4 backpressure on a 4x3 box
    run_tri(2560, 5120, 3584, 5120, 2560, 5888, 50);
    // T5 right/bottom clip
    run_tri(161280, 120320, 179200, 120320, 161280, 128000, 100);
    // Fully off-screen box
    run_tri(-2560, 100, -1024, 200, -1500, 300, 100);

    // T6 reset in the middle of a scan
    box_of(2560, 5120, 3584, 5120, 2560, 5888, xs, xe, ys, ye);
    push_pixels(xs, xe, ys, ye);
    rdy_pct = 100;
    base = xfer_cnt;
    offer(2560, 5120, 3584, 5120, 2560, 5888);
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (xfer_cnt >= base + 3) break;
    end
    chk("T6 transfers before reset", int'(xfer_cnt >= base + 3), 1);
    in_reset = 1;
    RESET = 1'b1;
    @(negedge CLK);
    check_reset_values("after mid-scan reset");
    RESET = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("no done after reset", int'(done), 0);
    end
    in_reset = 0;
    run_tri(384, 384, 768, 320, 576, 896, 100);

    // Random triangles under random backpressure
    for (int k = 0; k < 40; k++) begin
      bxp = int'($urandom_range(700)) - 30;
      byp = int'($urandom_range(540)) - 30;
      run_tri(rand_coord(bxp), rand_coord(byp), rand_coord(bxp), rand_coord(byp),
              rand_coord(bxp), rand_coord(byp), 30 + int'($urandom_range(70)));
    end

    repeat (2) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
